// File: rtl/apb_uart_ctrl_pkg.sv
// Shared types and register map for the apb_uart controller.
// Imported by the controller, its APB engine and the bench.
package apb_uart_ctrl_pkg;

  localparam logic [11:0] ADDR_TDR = 12'h000;
  localparam logic [11:0] ADDR_RDR = 12'h004;
  localparam logic [11:0] ADDR_FSR = 12'h008;
  localparam logic [11:0] ADDR_LCR = 12'h00C;
  localparam logic [11:0] ADDR_FCR = 12'h010;
  localparam logic [11:0] ADDR_HCR = 12'h014;
  localparam logic [11:0] ADDR_OCR = 12'h018;

  localparam int FSR_RX_NE_BIT = 1;
  localparam logic [31:0] OCR_TX_START = 32'h2;

  typedef enum logic [2:0] {
    UNCFG, CFG, IDLE, TX_DATA, TX_KICK, POLL, RD_DATA
  } uart_ctrl_state_e;

  typedef struct packed {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;

  function automatic xfer_t mk_wr(
    input logic [11:0] a,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    return '{write: 1'b1, addr: a, wdata: d, strb: s};
  endfunction

  function automatic xfer_t mk_rd(input logic [11:0] a);
    return '{write: 1'b0, addr: a, wdata: 32'h0, strb: 4'hF};
  endfunction

  function automatic logic [11:0] cfg_addr(input logic [1:0] i);
    case (i)
      2'd0:    return ADDR_LCR;
      2'd1:    return ADDR_FCR;
      2'd2:    return ADDR_HCR;
      default: return ADDR_OCR;
    endcase
  endfunction

endpackage

// File: rtl/apb_uart_ctrl_if.sv
// APB bus between the controller (master) and the apb_uart (slave).
interface apb_uart_ctrl_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pstrb, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_uart_ctrl_xfer.sv
// Single-transfer APB engine: one cmd per req, done on the pready edge.
// Holds addr/data/strb from SETUP until completion.
module apb_master_xfer
  import apb_uart_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req,
  input  xfer_t cmd,
  output logic  done,
  output logic [31:0] rdata,
  output logic  slverr,
  apb_uart_ctrl_if.master apb
);

  assign done   = apb.psel & apb.penable & apb.pready;
  assign rdata  = apb.prdata;
  assign slverr = apb.pslverr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pstrb   <= '0;
      apb.pwdata  <= '0;
    end else if (!apb.psel) begin
      if (req) begin
        apb.psel   <= 1'b1;
        apb.pwrite <= cmd.write;
        apb.paddr  <= cmd.addr;
        apb.pstrb  <= cmd.strb;
        apb.pwdata <= cmd.wdata;
      end
    end else if (!apb.penable) begin
      apb.penable <= 1'b1;
    end else if (apb.pready) begin
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
    end
  end

endmodule

// File: rtl/apb_uart_ctrl.sv
// APB sequencer for one apb_uart: config, TX stream into TDR,
// status polling and RDR reads out to the RX stream.
module apb_uart_ctrl
  import apb_uart_ctrl_pkg::*;
#(
  parameter logic [31:0] LCR_INIT = 32'h0000_0003,
  parameter logic [31:0] FCR_INIT = 32'h0000_0001,
  parameter logic [31:0] HCR_INIT = 32'h0000_0001,
  parameter logic [31:0] OCR_INIT = 32'h0000_0005,
  parameter int          POLL_DIV = 16
) (
  input  logic       clk,
  input  logic       preset_n,
  input  logic       cfg_start,
  output logic       cfg_done,
  output logic       err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       uart_irq,
  apb_uart_ctrl_if.master apb
);

  uart_ctrl_state_e state;
  xfer_t       cmd;
  logic        req;
  logic [1:0]  cfg_idx;
  logic        cfg_pend;
  logic        last_tx;
  logic [15:0] poll_cnt;
  logic        done;
  logic        slverr;
  logic [31:0] rdata;

  function automatic logic [31:0] cfg_data(input logic [1:0] i);
    case (i)
      2'd0:    return LCR_INIT;
      2'd1:    return FCR_INIT;
      2'd2:    return HCR_INIT;
      default: return OCR_INIT;
    endcase
  endfunction

  logic poll_max, poll_due, start_cfg, tx_go, poll_go;

  assign poll_max  = poll_cnt == 16'(POLL_DIV - 1);
  assign poll_due  = cfg_done && (poll_max || uart_irq) && !rx_valid;
  assign start_cfg = (cfg_start || cfg_pend) &&
                     (state == UNCFG || state == IDLE);
  // Round-robin: TX yields only when a poll is due and TX went last.
  assign tx_go     = state == IDLE && !start_cfg && tx_valid &&
                     (!poll_due || !last_tx);
  assign poll_go   = state == IDLE && !start_cfg && poll_due && !tx_go;
  assign tx_ready  = tx_go;

  apb_master_xfer u_xfer (
    .clk    (clk),
    .rst_n  (preset_n),
    .req    (req),
    .cmd    (cmd),
    .done   (done),
    .rdata  (rdata),
    .slverr (slverr),
    .apb    (apb)
  );

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state    <= UNCFG;
      cmd      <= '0;
      req      <= 1'b0;
      cfg_idx  <= '0;
      cfg_pend <= 1'b0;
      last_tx  <= 1'b0;
      poll_cnt <= '0;
      cfg_done <= 1'b0;
      err      <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done && slverr) err <= 1'b1;
      if (start_cfg) begin
        state    <= CFG;
        cfg_idx  <= '0;
        cfg_pend <= 1'b0;
        cfg_done <= 1'b0;
        err      <= 1'b0;
        req      <= 1'b1;
        cmd      <= mk_wr(ADDR_LCR, LCR_INIT, 4'hF);
      end else begin
        if (cfg_start) cfg_pend <= 1'b1;
        unique case (state)
          UNCFG: ;
          CFG: if (done) begin
            if (cfg_idx == 2'd3) begin
              state    <= IDLE;
              cfg_done <= 1'b1;
              req      <= 1'b0;
            end else begin
              cfg_idx <= cfg_idx + 2'd1;
              cmd     <= mk_wr(cfg_addr(cfg_idx + 2'd1),
                               cfg_data(cfg_idx + 2'd1), 4'hF);
            end
          end
          IDLE: begin
            if (!poll_max) poll_cnt <= poll_cnt + 16'd1;
            if (tx_go) begin
              state   <= TX_DATA;
              last_tx <= 1'b1;
              req     <= 1'b1;
              cmd     <= mk_wr(ADDR_TDR, {24'h0, tx_data}, 4'h1);
            end else if (poll_go) begin
              state    <= POLL;
              last_tx  <= 1'b0;
              poll_cnt <= '0;
              req      <= 1'b1;
              cmd      <= mk_rd(ADDR_FSR);
            end
          end
          TX_DATA: if (done) begin
            if (slverr) begin
              state <= IDLE;
              req   <= 1'b0;
            end else begin
              state <= TX_KICK;
              cmd   <= mk_wr(ADDR_OCR, OCR_INIT | OCR_TX_START, 4'h1);
            end
          end
          TX_KICK: if (done) begin
            state <= IDLE;
            req   <= 1'b0;
          end
          POLL: if (done) begin
            if (!slverr && rdata[FSR_RX_NE_BIT]) begin
              state <= RD_DATA;
              cmd   <= mk_rd(ADDR_RDR);
            end else begin
              state <= IDLE;
              req   <= 1'b0;
            end
          end
          RD_DATA: if (done) begin
            state <= IDLE;
            req   <= 1'b0;
            if (!slverr) begin
              rx_data  <= rdata[7:0];
              rx_valid <= 1'b1;
            end
          end
          default: state <= UNCFG;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Scoreboard bench: loopback APB slave model, expected writes and
// RX bytes queued by the stimulus, popped by monitors.
module tb_apb_uart_ctrl;
  import apb_uart_ctrl_pkg::*;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk = 1'b0;
  logic preset_n, cfg_start, cfg_done, err;
  logic [7:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, rx_ready, uart_irq;

  apb_uart_ctrl_if bus ();

  apb_uart_ctrl dut (
    .clk(clk), .preset_n(preset_n),
    .cfg_start(cfg_start), .cfg_done(cfg_done), .err(err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .uart_irq(uart_irq), .apb(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int acc_cnt = 0, wait_n = 0, n_xfer = 0, tdr_len = 0, rdy_cycles = 0;
  bit fail_tdr = 0;
  logic [11:0] s_addr;
  logic [31:0] s_wdata;
  logic [7:0] fifo[$];
  logic [7:0] rx_q[$];
  wr_t exp_wr[$];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Loopback slave: TDR writes land in the RX fifo read back via FSR/RDR.
  always @(negedge clk) begin
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    if (bus.psel && !bus.penable) begin
      s_addr  = bus.paddr;
      s_wdata = bus.pwdata;
      acc_cnt = 0;
    end else if (bus.psel && bus.penable) begin
      if (acc_cnt < wait_n) acc_cnt++;
      else begin
        n_xfer++;
        bus.pready = 1'b1;
        check("addr_stable", bus.paddr, s_addr);
        check("wdata_stable", bus.pwdata, s_wdata);
        if (bus.pwrite) begin
          if (bus.paddr == ADDR_TDR) begin
            tdr_len = acc_cnt + 1;
            if (fail_tdr) bus.pslverr = 1'b1;
            else fifo.push_back(bus.pwdata[7:0]);
          end
          if (exp_wr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, none expected",
                     bus.paddr, bus.pwdata);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            check("wr_addr", bus.paddr, e.addr);
            check("wr_data", bus.pwdata, e.data);
            check("wr_strb", bus.pstrb, e.strb);
          end
        end else begin
          logic [31:0] rd;
          rd = '0;
          check("rd_strb", bus.pstrb, 4'hF);
          check("rd_while_rx_valid", rx_valid, 1'b0);
          check("rd_addr", bus.paddr == ADDR_FSR || bus.paddr == ADDR_RDR, 1'b1);
          if (bus.paddr == ADDR_FSR) rd[FSR_RX_NE_BIT] = fifo.size() != 0;
          else if (fifo.size() != 0) rd = {24'h0, fifo.pop_front()};
          bus.prdata = rd;
        end
      end
    end else acc_cnt = 0;
  end

  always @(negedge clk) begin
    if (tx_ready) rdy_cycles++;
    if (preset_n && rx_valid && rx_ready) begin
      if (rx_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rx: got %0h, none expected", rx_data);
      end else check("rx_data", rx_data, rx_q.pop_front());
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    wr_t e;
    e.addr = a; e.data = d; e.strb = s;
    exp_wr.push_back(e);
  endtask

  task automatic send_tx(input logic [7:0] b, input bit fails);
    bit got = 0;
    push_wr(ADDR_TDR, {24'h0, b}, 4'h1);
    if (!fails) begin
      push_wr(ADDR_OCR, 32'h7, 4'h1);
      rx_q.push_back(b);
    end
    @(posedge clk); #1;
    tx_data = b; tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready) begin got = 1; break; end
    end
    check("tx_accept", got, 1'b1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_wr_empty();
    for (int i = 0; i < 600 && exp_wr.size() != 0; i++) @(negedge clk);
    check("wr_drain", exp_wr.size(), 0);
  endtask

  task automatic wait_rx_empty();
    for (int i = 0; i < 800 && rx_q.size() != 0; i++) @(negedge clk);
    check("rx_drain", rx_q.size(), 0);
  endtask

  task automatic do_cfg();
    push_wr(ADDR_LCR, 32'h3, 4'hF);
    push_wr(ADDR_FCR, 32'h1, 4'hF);
    push_wr(ADDR_HCR, 32'h1, 4'hF);
    push_wr(ADDR_OCR, 32'h5, 4'hF);
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    wait_wr_empty();
    @(negedge clk);
    check("cfg_done_after_cfg", cfg_done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    preset_n = 0; cfg_start = 0; tx_data = 0; tx_valid = 0;
    rx_ready = 1; uart_irq = 0;
    bus.prdata = 0; bus.pready = 0; bus.pslverr = 0;
    repeat (3) @(negedge clk);
    check("rst_psel", bus.psel, 1'b0);
    check("rst_penable", bus.penable, 1'b0);
    check("rst_cfg_done", cfg_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    preset_n = 1;
    // unconfigured: no TX grant, no polls
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h55;
    repeat (30) @(negedge clk);
    check("uncfg_no_xfer", n_xfer, 0);
    check("uncfg_no_tx_ready", rdy_cycles, 0);
    @(posedge clk); #1 tx_valid = 1'b0;

    do_cfg();

    rdy_cycles = 0;
    send_tx(8'hA5, 0);
    wait_wr_empty();
    check("tx_ready_one_cycle", rdy_cycles, 1);
    wait_rx_empty();

    for (int b = 1; b <= 5; b++) send_tx(8'(b), 0);
    wait_wr_empty();
    wait_rx_empty();
    check("loop_err", err, 1'b0);

    wait_n = 3;
    send_tx(8'hA5, 0);
    wait_wr_empty();
    check("wait_penable_len", tdr_len, 4);
    wait_rx_empty();
    wait_n = 0;

    @(posedge clk); #1 rx_ready = 1'b0;
    send_tx(8'hB1, 0);
    for (int i = 0; i < 300 && !rx_valid; i++) @(negedge clk);
    check("bp_rx_valid", rx_valid, 1'b1);
    send_tx(8'hC2, 0);
    wait_wr_empty();
    repeat (40) @(negedge clk);
    check("bp_rx_held", rx_valid, 1'b1);
    check("bp_rx_data", rx_data, 8'hB1);
    @(posedge clk); #1 rx_ready = 1'b1;
    wait_rx_empty();

    fail_tdr = 1;
    send_tx(8'h5A, 1);
    wait_wr_empty();
    repeat (30) @(negedge clk);
    check("slverr_err", err, 1'b1);
    check("slverr_cfg_kept", cfg_done, 1'b1);
    fail_tdr = 0;
    do_cfg();
    check("reconfig_clears_err", err, 1'b0);

    wait_n = 5;
    begin
      bit got = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.psel && bus.penable) begin got = 1; break; end
      end
      check("mid_access_seen", got, 1'b1);
    end
    preset_n = 0;
    #1;
    check("arst_psel", bus.psel, 1'b0);
    check("arst_penable", bus.penable, 1'b0);
    check("arst_cfg_done", cfg_done, 1'b0);
    repeat (2) @(negedge clk);
    preset_n = 1;
    wait_n = 0;
    repeat (5) @(negedge clk);
    check("end_wr_q", exp_wr.size(), 0);
    check("end_rx_q", rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
